// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with level flags and error pulses
//
// Purpose
//   Single-clock FIFO between a producer and a consumer that share one clock
//   domain. Storage is a simple dual-port register array (one write port, one
//   read port, same clock). Provides an occupancy count, full/empty, and
//   programmable almost-full/almost-empty levels. A refused write (FIFO full)
//   or a refused read (FIFO empty) raises a one-cycle error pulse.
//
// Build option
//   FIFO_FWFT_EN  defined   : first-word-fall-through; data_out shows the head
//                             word combinationally whenever empty==0 and re
//                             pops it.
//                 undefined : registered read; data_out loads the head word on
//                             the accepted-read edge and holds otherwise.
//
// Parameters
//   WIDTH     data word width in bits
//   DEPTH     number of entries (power of two, >= 2)
//   ADDR      log2(DEPTH)
//   AF_LEVEL  almost_full  when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//
// Ports
//   clk           in   1        clock, rising edge
//   rst_n         in   1        synchronous reset, active-low
//   we            in   1        write request
//   data_in       in   WIDTH    write data, taken with an accepted write
//   re            in   1        read request
//   data_out      out  WIDTH    read data
//   count         out  ADDR+1   occupancy 0..DEPTH
//   full          out  1        count == DEPTH
//   empty         out  1        count == 0
//   almost_full   out  1        count >= AF_LEVEL
//   almost_empty  out  1        count <= AE_LEVEL
//   overflow      out  1        one-cycle pulse after a refused write
//   underflow     out  1        one-cycle pulse after a refused read

module sync_fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ADDR     = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] data_in,
  input  logic             re,
  output logic [WIDTH-1:0] data_out,
  output logic [ADDR:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  // Count-width constants so every compare and increment is width-exact.
  localparam logic [ADDR:0] CNT_FULL = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] CNT_AF   = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0] CNT_AE   = (ADDR+1)'(AE_LEVEL);
  localparam logic [ADDR:0] ONE      = (ADDR+1)'(1);

  // Storage array: deliberately never reset. Stale words cannot leak out
  // because reading is gated by the count, which is cleared by reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]    count_q,  count_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;

  logic [ADDR-1:0]  wr_idx;
  logic [ADDR-1:0]  rd_idx;
  logic             full_w;
  logic             empty_w;
  logic             wr_accept;
  logic             rd_accept;

  assign wr_idx = wr_ptr_q[ADDR-1:0];
  assign rd_idx = rd_ptr_q[ADDR-1:0];

  // Flags are a pure decode of the registered count, so they move on the
  // cycle after the operation that changed the count.
  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // Gating on full/empty alone also resolves simultaneous requests: when
  // full only the read goes through, when empty only the write goes through.
  assign wr_accept = we && !full_w;
  assign rd_accept = re && !empty_w;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = we && full_w;
    underflow_d = re && empty_w;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end

    if (wr_accept && !rd_accept) begin
      count_d = count_q + ONE;
    end else if (rd_accept && !wr_accept) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Write port of the register array.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept) begin
      mem_q[wr_idx] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; meaningless while empty.
  assign data_out = mem_q[rd_idx];
`else
  logic [WIDTH-1:0] data_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (rd_accept) begin
      data_out_q <= mem_q[rd_idx];
    end
  end

  assign data_out = data_out_q;
`endif

  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param

module tb_sync_fifo_param;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int ADDR  = 3;
  localparam int AFL   = 6;
  localparam int AEL   = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             we;
  logic [WIDTH-1:0] data_in;
  logic             re;
  logic [WIDTH-1:0] data_out;
  logic [ADDR:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .data_in(data_in), .re(re),
    .data_out(data_out), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] sb[$];
  int               exp_cnt;
  logic [WIDTH-1:0] last_dout;
  logic [WIDTH-1:0] popped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
    chk({tag, ".full"}, 32'(full), 32'(exp_cnt == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(exp_cnt >= AFL));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(exp_cnt <= AEL));
  endtask

  // One clock cycle with the given requests; the bench model decides what
  // should be accepted and checks everything #1 after the edge.
  task automatic do_op(input string tag, input logic w, input logic [WIDTH-1:0] wd,
                       input logic r);
    logic wacc, racc, eovf, eunf;
    wacc = w && (exp_cnt != DEPTH);
    racc = r && (exp_cnt != 0);
    eovf = w && (exp_cnt == DEPTH);
    eunf = r && (exp_cnt == 0);
`ifdef FIFO_FWFT_EN
    if (racc) chk({tag, ".fwft_head"}, 32'(data_out), 32'(sb[0]));
`endif
    we = w; data_in = wd; re = r;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    if (racc) popped = sb.pop_front();
    if (wacc) sb.push_back(wd);
    exp_cnt = exp_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
    chk_status(tag);
    chk({tag, ".overflow"}, 32'(overflow), 32'(eovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(eunf));
`ifndef FIFO_FWFT_EN
    if (racc) begin
      chk({tag, ".rdata"}, 32'(data_out), 32'(popped));
      last_dout = popped;
    end else begin
      chk({tag, ".hold"}, 32'(data_out), 32'(last_dout));
    end
`endif
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; we = 1'b0; re = 1'b0; data_in = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = 0;
    last_dout = '0;
    chk_status(tag);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
    chk({tag, ".underflow"}, 32'(underflow), 32'd0);
`ifndef FIFO_FWFT_EN
    chk({tag, ".dout"}, 32'(data_out), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; data_in = '0;
    exp_cnt = 0; last_dout = '0; popped = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Fill 0x0001..0x0008; flags checked after every write.
    for (int i = 1; i <= DEPTH; i++) do_op("fill", 1'b1, 16'(i), 1'b0);

    // Write while full: refused, one-cycle overflow pulse.
    do_op("ovf", 1'b1, 16'hDEAD, 1'b0);
    do_op("ovf_idle", 1'b0, '0, 1'b0);

    // Drain in order, then read while empty.
    for (int i = 0; i < DEPTH; i++) do_op("drain", 1'b0, '0, 1'b1);
    do_op("unf", 1'b0, '0, 1'b1);
    do_op("unf_idle", 1'b0, '0, 1'b0);

    // Pointer wrap: 5 in/out, then 6 more crossing index 7 -> 0.
    for (int i = 0; i < 5; i++) do_op("wrap_w1", 1'b1, 16'(16'h0100 + i), 1'b0);
    for (int i = 0; i < 5; i++) do_op("wrap_r1", 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) do_op("wrap_w2", 1'b1, 16'(16'h0200 + i), 1'b0);
    for (int i = 0; i < 6; i++) do_op("wrap_r2", 1'b0, '0, 1'b1);

    // Simultaneous read+write at count 4 for 20 cycles.
    for (int i = 0; i < 4; i++) do_op("sim_pre", 1'b1, 16'($urandom_range(0, 65535)), 1'b0);
    for (int i = 0; i < 20; i++) do_op("sim_rw", 1'b1, 16'($urandom_range(0, 65535)), 1'b1);

    // Simultaneous at full: read accepted, write refused.
    for (int i = 0; i < 4; i++) do_op("sim_fill", 1'b1, 16'(16'h0300 + i), 1'b0);
    do_op("sim_full", 1'b1, 16'hBEEF, 1'b1);
    do_op("sim_full_idle", 1'b0, '0, 1'b0);

    // Simultaneous at empty: write accepted, read refused.
    while (exp_cnt > 0) do_op("sim_drain", 1'b0, '0, 1'b1);
    do_op("sim_empty", 1'b1, 16'h5A5A, 1'b1);
    do_op("sim_empty_rd", 1'b0, '0, 1'b1);

    // Reset with 5 entries stored, then new data flows normally.
    for (int i = 0; i < 5; i++) do_op("pre_rst", 1'b1, 16'(16'h0400 + i), 1'b0);
    do_reset("mid_reset");
    do_op("post_w", 1'b1, 16'h1234, 1'b0);
    do_op("post_w", 1'b1, 16'h5678, 1'b0);
    do_op("post_r", 1'b0, '0, 1'b1);
    do_op("post_r", 1'b0, '0, 1'b1);
    do_op("post_unf", 1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
